// File: rtl/kanagawa_ram_read_stream.sv
// Read-side stream controller for a fixed-latency synchronous RAM read port.
// Define KANAGAWA_RAM_READ_STREAM_STATS_EN to add the stall_cycles / max_occupancy counters.
module kanagawa_ram_read_stream #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    output logic [ADDR_WIDTH-1:0]       ram_rdaddr,
    output logic                        ram_rden,
    input  logic [DATA_WIDTH-1:0]       ram_q,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
    output logic [31:0]                 stall_cycles,
    output logic [$clog2(FIFO_DEPTH):0] max_occupancy,
`endif
    output logic                        idle
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = 8;

    logic [READ_LATENCY-1:0] sr_q, sr_d;
    logic [PW-1:0]           wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [SW-1:0]           inflight, credit_used;
    logic                    issue, wr, deq;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + SW'(sr_q[i]);
    end

    // Credit uses only registered state, so req_ready never depends on out_ready/req_valid.
    assign credit_used = inflight + SW'(cnt_q);
    assign req_ready   = credit_used < SW'(FIFO_DEPTH);
    assign issue       = req_valid && req_ready && !rst;
    assign ram_rden    = issue;
    assign ram_rdaddr  = req_addr;

    assign wr        = sr_q[READ_LATENCY-1];
    assign out_valid = (cnt_q != '0);
    assign deq       = out_valid && out_ready;
    assign out_data  = mem_q[rp_q];
    assign idle      = (sr_q == '0) && (cnt_q == '0);

    always_comb begin
        sr_d    = sr_q << 1;
        sr_d[0] = issue;
        wp_d    = wp_q + PW'(wr);
        rp_d    = rp_q + PW'(deq);
        cnt_d   = cnt_q + CW'(wr) - CW'(deq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately unreset; only count/pointers define validity.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= ram_q;
    end

    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(wr && cnt_q == CW'(FIFO_DEPTH)));

`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
    logic [31:0]   stall_q, stall_d;
    logic [CW-1:0] maxocc_q, maxocc_d;

    always_comb begin
        stall_d  = stall_q;
        maxocc_d = maxocc_q;
        if (out_valid && !out_ready && stall_q != '1) stall_d = stall_q + 32'd1;
        if (cnt_q > maxocc_q) maxocc_d = cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            maxocc_q <= '0;
        end else begin
            stall_q  <= stall_d;
            maxocc_q <= maxocc_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign max_occupancy = maxocc_q;
`endif
endmodule

// File: tb/tb_kanagawa_ram_read_stream.sv
// Bench for kanagawa_ram_read_stream: RAM model plus a queue-based reference of issued-but-undequeued words.
module tb_kanagawa_ram_read_stream;
    localparam int DW = 32, AW = 9, RL = 2, FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, ram_rden, out_valid, out_ready, idle;
    logic [AW-1:0] req_addr, ram_rdaddr;
    logic [DW-1:0] ram_q, out_data;
`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
    logic [31:0]   stall_cycles;
    logic [$clog2(FD):0] max_occupancy;
`endif

    always #5 clk = ~clk;

    kanagawa_ram_read_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .ram_rdaddr(ram_rdaddr), .ram_rden(ram_rden), .ram_q(ram_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
        .stall_cycles(stall_cycles), .max_occupancy(max_occupancy),
`endif
        .idle(idle));

    // Registered-address, registered-output RAM: latency 2.
    logic [DW-1:0] mem [1<<AW];
    logic [AW-1:0] a1;
    always @(posedge clk) begin
        a1    <= ram_rdaddr;
        ram_q <= mem[a1];
    end

    // Reference: every accepted request is one credit until dequeued; its word is visible RL+1 cycles later.
    typedef struct { logic [DW-1:0] data; int avail; } ent_t;
    ent_t exp_q[$];
    int   cyc, n_chk, n_pass, stall_m, maxocc_m;
    logic e_ready, e_valid, e_idle;
    logic [DW-1:0] e_data;

    task automatic model_eval();
        e_ready = exp_q.size() < FD;
        e_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        e_data  = (exp_q.size() > 0) ? exp_q[0].data : '0;
        e_idle  = (exp_q.size() == 0);
    endtask

    task automatic model_clear();
        exp_q.delete();
        cyc = 0; stall_m = 0; maxocc_m = 0;
    endtask

    task automatic model_edge();
        int   occ;
        ent_t e;
        model_eval();
        occ = 0;
        foreach (exp_q[k]) if (exp_q[k].avail <= cyc) occ++;
        if (occ > maxocc_m) maxocc_m = occ;
        if (e_valid && !out_ready) stall_m++;
        if (e_valid && out_ready) void'(exp_q.pop_front());
        if (req_valid && e_ready) begin
            e.data = mem[req_addr]; e.avail = cyc + RL + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_addr = '0; out_ready = 1'b0;
        #2;
        n_chk++;
        if ({req_ready, out_valid, ram_rden, idle} !== 4'b1001)
            $display("FAIL reset_async got rdy/vld/rden/idle=%b want 1001", {req_ready, out_valid, ram_rden, idle});
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if ({req_ready, out_valid, ram_rden, idle} !== 4'b1001)
            $display("FAIL reset_hold got rdy/vld/rden/idle=%b want 1001", {req_ready, out_valid, ram_rden, idle});
        else n_pass++;
        rst = 1'b0; req_valid = 1'b0;
        model_clear();
    endtask

    task automatic test_single();
        logic [35:0] obs, expv;
        int first = -1;
        mem[5] = 32'hDEADBEEF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = (i == 0); req_addr = 9'h005;
            @(negedge clk); model_eval();
            obs  = {req_ready, ram_rden, out_valid, idle, e_valid ? out_data : 32'h0};
            expv = {e_ready, req_valid && e_ready, e_valid, e_idle, e_valid ? e_data : 32'h0};
            n_chk++;
            if (obs !== expv) $display("FAIL single cyc=%0d got %h want %h", cyc, obs, expv);
            else n_pass++;
            if (out_valid && first < 0) first = i;
            model_edge();
        end
        n_chk++;
        if (first !== 3) $display("FAIL single_latency got %0d want 3", first);
        else n_pass++;
        n_chk++;
        if (idle !== 1'b1) $display("FAIL single_idle got %b want 1", idle);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [35:0] obs, expv;
        int drops = 0, nout = 0, fo = -1, lo = -1;
        out_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            req_valid = (i < 16); req_addr = AW'(i);
            @(negedge clk); model_eval();
            obs  = {req_ready, ram_rden, out_valid, idle, e_valid ? out_data : 32'h0};
            expv = {e_ready, req_valid && e_ready, e_valid, e_idle, e_valid ? e_data : 32'h0};
            n_chk++;
            if (obs !== expv) $display("FAIL b2b cyc=%0d got %h want %h", cyc, obs, expv);
            else n_pass++;
            if (req_valid && !req_ready) drops++;
            if (out_valid) begin nout++; if (fo < 0) fo = i; lo = i; end
            model_edge();
        end
        n_chk++;
        if (drops !== 0) $display("FAIL b2b_ready_drops got %0d want 0", drops);
        else n_pass++;
        n_chk++;
        if (nout !== 16 || lo - fo !== 15) $display("FAIL b2b_words got n=%0d span=%0d want n=16 span=15", nout, lo - fo);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [35:0] obs, expv;
        int acc = 0, deq_i = -1, rdy_i = -1;
        for (int i = 0; i < 24; i++) begin
            out_ready = (i >= 8); req_valid = (i < 16); req_addr = AW'($urandom);
            @(negedge clk); model_eval();
            obs  = {req_ready, ram_rden, out_valid, idle, e_valid ? out_data : 32'h0};
            expv = {e_ready, req_valid && e_ready, e_valid, e_idle, e_valid ? e_data : 32'h0};
            n_chk++;
            if (obs !== expv) $display("FAIL backpressure cyc=%0d got %h want %h", cyc, obs, expv);
            else n_pass++;
            if (i < 8 && req_valid && req_ready) acc++;
            if (i >= 8 && out_valid && out_ready && deq_i < 0) deq_i = i;
            if (i >= 8 && req_ready && rdy_i < 0) rdy_i = i;
            model_edge();
        end
        n_chk++;
        if (acc !== 4) $display("FAIL bp_accepted got %0d want 4", acc);
        else n_pass++;
        n_chk++;
        if (rdy_i !== deq_i + 1) $display("FAIL bp_credit_return got %0d want %0d", rdy_i, deq_i + 1);
        else n_pass++;
    endtask

    task automatic test_alternating();
        logic [35:0] obs, expv;
        int acc = 0, deq = 0;
        for (int i = 0; i < 280; i++) begin
            if (i < 60)       begin out_ready = i[0]; req_valid = 1'b1; end
            else if (i < 260) begin out_ready = $urandom_range(0, 1) != 0; req_valid = $urandom_range(0, 3) != 0; end
            else              begin out_ready = 1'b1; req_valid = 1'b0; end
            req_addr = AW'($urandom);
            @(negedge clk); model_eval();
            obs  = {req_ready, ram_rden, out_valid, idle, e_valid ? out_data : 32'h0};
            expv = {e_ready, req_valid && e_ready, e_valid, e_idle, e_valid ? e_data : 32'h0};
            n_chk++;
            if (obs !== expv) $display("FAIL alternating cyc=%0d got %h want %h", cyc, obs, expv);
            else n_pass++;
            if (req_valid && req_ready) acc++;
            if (out_valid && out_ready) deq++;
            model_edge();
        end
        n_chk++;
        if (acc !== deq || idle !== 1'b1) $display("FAIL alt_conservation got acc=%0d deq=%0d idle=%b want equal,1", acc, deq, idle);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        logic [35:0] obs, expv;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = (i < 3); req_addr = AW'($urandom);
            @(negedge clk); model_eval();
            obs  = {req_ready, ram_rden, out_valid, idle, e_valid ? out_data : 32'h0};
            expv = {e_ready, req_valid && e_ready, e_valid, e_idle, e_valid ? e_data : 32'h0};
            n_chk++;
            if (obs !== expv) $display("FAIL midrst_fill cyc=%0d got %h want %h", cyc, obs, expv);
            else n_pass++;
            if (i < 3) model_edge();
        end
        // now one word buffered and two reads in flight
        rst = 1'b1; req_valid = 1'b1;
        #1;
        n_chk++;
        if ({req_ready, out_valid, ram_rden, idle} !== 4'b1001)
            $display("FAIL midrst_async got rdy/vld/rden/idle=%b want 1001", {req_ready, out_valid, ram_rden, idle});
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        model_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_valid = (i == 6); req_addr = AW'($urandom);
            @(negedge clk); model_eval();
            obs  = {req_ready, ram_rden, out_valid, idle, e_valid ? out_data : 32'h0};
            expv = {e_ready, req_valid && e_ready, e_valid, e_idle, e_valid ? e_data : 32'h0};
            n_chk++;
            if (obs !== expv) $display("FAIL midrst_after cyc=%0d got %h want %h", cyc, obs, expv);
            else n_pass++;
            model_edge();
        end
    endtask

`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
    task automatic test_stats();
        logic [35:0] obs, expv;
        rst = 1'b1; #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            req_valid = (i == 0); req_addr = AW'($urandom);
            @(negedge clk); model_eval();
            obs  = {req_ready, ram_rden, out_valid, idle, e_valid ? out_data : 32'h0};
            expv = {e_ready, req_valid && e_ready, e_valid, e_idle, e_valid ? e_data : 32'h0};
            n_chk++;
            if (obs !== expv) $display("FAIL stats cyc=%0d got %h want %h", cyc, obs, expv);
            else n_pass++;
            model_edge();
        end
        n_chk++;
        if (stall_cycles !== 32'd10 || stall_cycles !== 32'(stall_m))
            $display("FAIL stats_stall got %0d want 10 (model %0d)", stall_cycles, stall_m);
        else n_pass++;
        n_chk++;
        if (max_occupancy < 1 || int'(max_occupancy) !== maxocc_m)
            $display("FAIL stats_maxocc got %0d want %0d", max_occupancy, maxocc_m);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) model_edge();
    endtask
`endif

    initial begin
        n_chk = 0; n_pass = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_alternating();
        test_reset_midflight();
`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
